migu_alu_arbiter: RTL and testbench
===================================

# migu_alu_arbiter

Two-requester arbiter and response stage that shares one `MigUAlu` instance inside the mig-u core. Each requester hands in an operation with a valid/ready handshake. The block picks one request per cycle by round-robin, with an optional lock that keeps back-to-back sequences together. It evaluates the pick on the shared ALU and registers the result into a single response slot held until the consumer accepts it.

## Interface
Parameters:
- `WIDTH`, 64, operand/result width passed to `MigUAlu`
- `NR_REQ`, 2, number of requesters (fixed at 2; other values are illegal)

Ports:
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  2  per-requester request valid
- `req_ready`  out  2  per-requester accept; request accepted when valid & ready
- `req_lock`  in  2  requester asks to keep grant after this op
- `req_cmd`  in  2×MIGU_ALU_CMD_WIDTH  ALU command per requester
- `req_in1`, `req_in2`  in  2×WIDTH  operands per requester
- `rsp_valid`  out  1  response slot full
- `rsp_ready`  in  1  consumer takes response
- `rsp_id`  out  1  requester index of response
- `rsp_out`  out  WIDTH  ALU result
- `rsp_co`  out  1  ALU carry-out
- `rsp_err`  out  1  command was ≥ MIGU_ALU_NR_COMMANDS

## Operation
- Slot free when `!rsp_valid || rsp_ready`. At most one `req_ready` bit is high, and only if the slot is free.
- Arbitration in state IDLE:
  - Grant the requester with `req_valid` whose index equals `prio`; otherwise grant the other one if valid.
  - On an accept, `prio` moves to the non-granted index.
- FSM states are IDLE and LOCKED(owner).
- IDLE → LOCKED(i) when requester i is accepted with `req_lock[i]=1`.
- In LOCKED(i) only requester i can be granted. The other requester's `req_ready` stays 0 even when requester i is idle.
- LOCKED(i) → IDLE when requester i is accepted with `req_lock[i]=0`. `prio` then moves to the other index.
- LOCKED(i) → IDLE when requester i drops `req_valid` for 16 consecutive cycles (lock timeout). This uses a 4-bit counter that clears on every accept from the owner. `prio` is unchanged on timeout.
- On an accept, the ALU runs combinationally on the granted operands. The slot then loads `rsp_id`, `rsp_out`, `rsp_co` and `rsp_err`.
- Bad command (`cmd ≥ MIGU_ALU_NR_COMMANDS`): `rsp_err=1`, `rsp_out=0`, `rsp_co=0`. The request is still consumed and still counts for arbitration.
- Slot contents stay stable while `rsp_valid & !rsp_ready`.
- A pop and a new accept in the same cycle are allowed. The slot reloads with no bubble.

## Timing
- Latency: accept in cycle N → `rsp_valid=1` with its result in N+1.
- Throughput: 1 op/cycle while `rsp_ready=1`.
- `req_ready` is combinational from `req_valid`, state, `prio`, `rsp_valid` and `rsp_ready`. It has no path from `req_cmd`, `req_in1` or `req_in2`.
- Reset values:
  - `rsp_valid=0`, `rsp_id=0`, `rsp_out=0`, `rsp_co=0`, `rsp_err=0`
  - state IDLE, `prio=0`, timeout counter 0
  - `req_ready=0` during the reset cycle
- Reset asserted mid-operation: a pending response is dropped and any lock is released, with no residual state.
- `rsp_ready` while `rsp_valid=0` is ignored.
- `req_lock` is sampled only on an accepted cycle.

## Structure
- `migu_pkg` holds:
  - existing `MIGU_ALU_CMD_WIDTH` and `MIGU_ALU_NR_COMMANDS`
  - new `MIGU_ALU_ARB_LOCK_TIMEOUT` (16)
  - new typedef `migu_alu_arb_state_t` {IDLE, LOCKED}
- The only sub-module is one `MigUAlu` instance. Arbitration, FSM and the response register live in `migu_alu_arbiter`.
- The command range check sits in the arbiter, on the granted `req_cmd`.

## Test plan
- Reset, then both requesters valid every cycle with lock=0 → grants alternate 0,1,0,1. Each response appears the cycle after its accept with the matching `rsp_id`.
- `rsp_ready=0` for 3 cycles with the slot full → both `req_ready=0`. `rsp_out` and `rsp_id` are held. `rsp_ready=1` → pop and a new accept happen in the same cycle.
- Requester 1 sends 3 ops with lock=1,1,0 while requester 0 is continuously valid → three consecutive `rsp_id=1`, then `rsp_id=0`.
- Requester 0 locks, then goes idle for 16 cycles while requester 1 is valid → requester 1 first granted on cycle 17 after the last owner accept.
- `req_cmd=MIGU_ALU_NR_COMMANDS` → `rsp_err=1`, `rsp_out=0`, `rsp_co=0`, with the next valid command unaffected. `in1=2^64-1`, `in2=1` with the add command → `rsp_out=0`, `rsp_co=1`.
- Assert `rst` while locked with a response pending → next cycle `rsp_valid=0`, state IDLE, `prio=0`.

Source files
------------

// File: rtl/migu_pkg.sv
// migu_pkg: shared types and constants for the mig-u ALU and its arbiter.
//   MIGU_ALU_CMD_WIDTH        width of an ALU command
//   MIGU_ALU_NR_COMMANDS      number of legal commands; codes at or above are illegal
//   MIGU_ALU_ARB_LOCK_TIMEOUT idle cycles after which an unused lock is released
//   migu_alu_cmd_e            command encoding
//   migu_alu_arb_state_t      arbiter FSM state
package migu_pkg;

  localparam int MIGU_ALU_CMD_WIDTH = 4;
  localparam logic [MIGU_ALU_CMD_WIDTH-1:0] MIGU_ALU_NR_COMMANDS = 4'd10;
  localparam int MIGU_ALU_ARB_LOCK_TIMEOUT = 16;

  typedef enum logic [MIGU_ALU_CMD_WIDTH-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } migu_alu_cmd_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } migu_alu_arb_state_t;

  function automatic logic migu_alu_cmd_bad(input logic [MIGU_ALU_CMD_WIDTH-1:0] cmd);
    return cmd >= MIGU_ALU_NR_COMMANDS;
  endfunction

endpackage

// File: rtl/migu_alu_arbiter_if.sv
// migu_alu_arbiter_if: request/response bundle between requesters, consumer
// and migu_alu_arbiter.
//   req_valid/req_ready/req_lock  per-requester handshake and lock request
//   req_cmd/req_in1/req_in2       per-requester ALU command and operands
//   rsp_valid/rsp_ready           response slot handshake
//   rsp_id/rsp_out/rsp_co/rsp_err response payload
// modport slave is the arbiter side, master the requester/consumer side.
interface migu_alu_arbiter_if #(
  parameter int WIDTH  = 64,
  parameter int NR_REQ = 2
);
  import migu_pkg::*;

  logic [NR_REQ-1:0]                         req_valid;
  logic [NR_REQ-1:0]                         req_ready;
  logic [NR_REQ-1:0]                         req_lock;
  logic [NR_REQ-1:0][MIGU_ALU_CMD_WIDTH-1:0] req_cmd;
  logic [NR_REQ-1:0][WIDTH-1:0]              req_in1;
  logic [NR_REQ-1:0][WIDTH-1:0]              req_in2;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_out;
  logic             rsp_co;
  logic             rsp_err;

  modport master (
    output req_valid, req_lock, req_cmd, req_in1, req_in2, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_out, rsp_co, rsp_err
  );

  modport slave (
    input  req_valid, req_lock, req_cmd, req_in1, req_in2, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_out, rsp_co, rsp_err
  );

endinterface

// File: rtl/migu_alu.sv
// MigUAlu: combinational mig-u ALU.
//   cmd_i        command (migu_alu_cmd_e); unknown codes give out=0, co=0
//   in1_i, in2_i operands
//   out_o        result
//   co_o         carry-out for ADD, no-borrow (in1 >= in2 unsigned) for SUB, else 0
module MigUAlu
  import migu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [MIGU_ALU_CMD_WIDTH-1:0] cmd_i,
  input  logic [WIDTH-1:0]              in1_i,
  input  logic [WIDTH-1:0]              in2_i,
  output logic [WIDTH-1:0]              out_o,
  output logic                          co_o
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   shamt;

  always_comb begin
    sum   = {1'b0, in1_i} + {1'b0, in2_i};
    // in1 + ~in2 + 1: top bit is the inverted borrow
    diff  = {1'b0, in1_i} + {1'b0, ~in2_i} + {{WIDTH{1'b0}}, 1'b1};
    shamt = in2_i[SHW-1:0];
    out_o = '0;
    co_o  = 1'b0;
    case (cmd_i)
      ALU_ADD:  begin out_o = sum[WIDTH-1:0];  co_o = sum[WIDTH];  end
      ALU_SUB:  begin out_o = diff[WIDTH-1:0]; co_o = diff[WIDTH]; end
      ALU_AND:  out_o = in1_i & in2_i;
      ALU_OR:   out_o = in1_i | in2_i;
      ALU_XOR:  out_o = in1_i ^ in2_i;
      ALU_SLL:  out_o = in1_i << shamt;
      ALU_SRL:  out_o = in1_i >> shamt;
      ALU_SRA:  out_o = $signed(in1_i) >>> shamt;
      ALU_SLT:  out_o = {{(WIDTH-1){1'b0}}, $signed(in1_i) < $signed(in2_i)};
      ALU_SLTU: out_o = {{(WIDTH-1){1'b0}}, in1_i < in2_i};
      default:  ;
    endcase
  end

endmodule

// File: rtl/migu_alu_arbiter.sv
// migu_alu_arbiter: two-requester round-robin arbiter in front of one shared
// MigUAlu, with an optional grant lock and a single registered response slot.
//   clk   clock, all state on rising edge
//   rst   synchronous active-high reset
//   bus   migu_alu_arbiter_if.slave: requests in, one response out
// NR_REQ must be 2; the index logic below is written for a 1-bit requester id.
module migu_alu_arbiter
  import migu_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int NR_REQ = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  migu_alu_arbiter_if.slave     bus
);

  localparam int TMO_W = $clog2(MIGU_ALU_ARB_LOCK_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MIGU_ALU_ARB_LOCK_TIMEOUT - 1);

  migu_alu_arb_state_t state_q, state_d;
  logic                owner_q, owner_d;
  logic                prio_q,  prio_d;
  logic [TMO_W-1:0]    tmo_q,   tmo_d;

  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_id_q,    rsp_id_d;
  logic [WIDTH-1:0]    rsp_out_q,   rsp_out_d;
  logic                rsp_co_q,    rsp_co_d;
  logic                rsp_err_q,   rsp_err_d;

  logic                          slot_free;
  logic                          gnt_vld;
  logic                          gnt_idx;
  logic                          accept;
  logic [NR_REQ-1:0]             ready;
  logic [MIGU_ALU_CMD_WIDTH-1:0] cmd_g;
  logic [WIDTH-1:0]              in1_g, in2_g;
  logic                          cmd_bad;
  logic [WIDTH-1:0]              alu_out;
  logic                          alu_co;

  // Grant selection: depends only on valids, FSM state, prio and slot state,
  // never on the operand/command fields.
  always_comb begin
    slot_free = !rsp_valid_q || bus.rsp_ready;
    gnt_vld   = 1'b0;
    gnt_idx   = prio_q;
    if (state_q == LOCKED) begin
      // Owner only; the other requester waits even while the owner is idle.
      gnt_idx = owner_q;
      gnt_vld = bus.req_valid[owner_q];
    end else if (bus.req_valid[prio_q]) begin
      gnt_idx = prio_q;
      gnt_vld = 1'b1;
    end else if (bus.req_valid[~prio_q]) begin
      gnt_idx = ~prio_q;
      gnt_vld = 1'b1;
    end
    accept         = gnt_vld && slot_free && !rst;
    ready          = '0;
    ready[gnt_idx] = accept;
  end

  assign bus.req_ready = ready;

  assign cmd_g   = bus.req_cmd[gnt_idx];
  assign in1_g   = bus.req_in1[gnt_idx];
  assign in2_g   = bus.req_in2[gnt_idx];
  assign cmd_bad = migu_alu_cmd_bad(cmd_g);

  MigUAlu #(.WIDTH(WIDTH)) u_alu (
    .cmd_i (cmd_g),
    .in1_i (in1_g),
    .in2_i (in2_g),
    .out_o (alu_out),
    .co_o  (alu_co)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    prio_d      = prio_q;
    tmo_d       = tmo_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_out_d   = rsp_out_q;
    rsp_co_d    = rsp_co_q;
    rsp_err_d   = rsp_err_q;

    if (accept) begin
      // Slot reloads even when it is being popped this cycle (no bubble).
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_idx;
      rsp_err_d   = cmd_bad;
      rsp_out_d   = cmd_bad ? '0 : alu_out;
      rsp_co_d    = !cmd_bad && alu_co;
      prio_d      = ~gnt_idx;
      tmo_d       = '0;
      if (state_q == IDLE) begin
        if (bus.req_lock[gnt_idx]) begin
          state_d = LOCKED;
          owner_d = gnt_idx;
        end
      end else if (!bus.req_lock[gnt_idx]) begin
        state_d = IDLE;
      end
    end else begin
      if (bus.rsp_ready) rsp_valid_d = 1'b0;
      if (state_q == LOCKED) begin
        // Timeout counts consecutive owner-idle cycles; a valid but stalled
        // owner breaks the run. prio is left alone on release.
        if (bus.req_valid[owner_q]) begin
          tmo_d = '0;
        end else if (tmo_q == TMO_MAX) begin
          state_d = IDLE;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      prio_q      <= 1'b0;
      tmo_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_out_q   <= '0;
      rsp_co_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      prio_q      <= prio_d;
      tmo_q       <= tmo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_out_q   <= rsp_out_d;
      rsp_co_q    <= rsp_co_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_out   = rsp_out_q;
  assign bus.rsp_co    = rsp_co_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_migu_alu_arbiter.sv
// Testbench for migu_alu_arbiter: directed grant-order checks plus a
// scoreboard that predicts every response from the accepted request.
module tb_migu_alu_arbiter;
  import migu_pkg::*;

  localparam int W = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  migu_alu_arbiter_if #(.WIDTH(W), .NR_REQ(2)) bus ();
  migu_alu_arbiter #(.WIDTH(W), .NR_REQ(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference ALU: returns {id, err, co, out}
  function automatic logic [66:0] model(input logic id, input logic [3:0] cmd,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [63:0] o;
    logic co, err;
    o = '0; co = 1'b0; err = 1'b0;
    case (cmd)
      4'd0: begin o = a + b; co = (o < a); end
      4'd1: begin o = a - b; co = (a >= b); end
      4'd2: o = a & b;
      4'd3: o = a | b;
      4'd4: o = a ^ b;
      4'd5: o = a << b[5:0];
      4'd6: o = a >> b[5:0];
      4'd7: o = $signed(a) >>> b[5:0];
      4'd8: o = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'd9: o = (a < b) ? 64'd1 : 64'd0;
      default: err = 1'b1;
    endcase
    return {id, err, co, o};
  endfunction

  // Scoreboard monitor
  logic [66:0] sb_q[$];
  logic [66:0] last_exp = '0;
  bit          acc_prev = 1'b0;
  bit          hold_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      acc_prev  = 1'b0;
      hold_prev = 1'b0;
    end else begin
      if (acc_prev) begin
        if (sb_q.size() == 0) chk("sb_empty", 1, 0);
        else begin
          last_exp = sb_q.pop_front();
          chk("rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_co, bus.rsp_out},
              {1'b1, last_exp});
        end
      end else if (hold_prev) begin
        chk("hold", {bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_co, bus.rsp_out},
            {1'b1, last_exp});
      end else begin
        chk("no_rsp", bus.rsp_valid, 0);
      end
      chk("rdy_onehot", bus.req_ready == 2'b11, 0);
      chk("rdy_valid", bus.req_ready & ~bus.req_valid, 0);
      chk("rdy_free", (bus.req_ready != 0) && bus.rsp_valid && !bus.rsp_ready, 0);
      acc_prev = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          sb_q.push_back(model(1'(i), bus.req_cmd[i], bus.req_in1[i], bus.req_in2[i]));
          acc_prev = 1'b1;
        end
      end
      hold_prev = bus.rsp_valid && !bus.rsp_ready;
    end
  end

  bit auto_ops = 1'b1;

  task automatic rnd_op(input int i);
    bus.req_cmd[i] = 4'($urandom_range(0, 11));
    bus.req_in1[i] = {$urandom, $urandom};
    bus.req_in2[i] = {$urandom, $urandom};
  endtask

  // One cycle: optional req_ready check at negedge, then advance to posedge+1
  // and give accepted requesters a fresh operation.
  task automatic cyc(input string tag, input bit do_chk, input logic [1:0] exp_rdy);
    logic [1:0] acc;
    @(negedge clk);
    if (do_chk) chk(tag, bus.req_ready, exp_rdy);
    acc = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    if (auto_ops)
      for (int i = 0; i < 2; i++) if (acc[i]) rnd_op(i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 2'b11;
    bus.req_lock  = 2'b00;
    bus.rsp_ready = 1'b1;
    rnd_op(0);
    rnd_op(1);

    // Reset: no grant while rst is high
    cyc("rst_rdy", 1, 2'b00);
    cyc("rst_rdy", 1, 2'b00);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_co, bus.rsp_out}, 0);
    rst = 1'b0;

    // Round robin with both valid
    for (int k = 0; k < 6; k++) cyc("rr", 1, (k % 2 == 0) ? 2'b01 : 2'b10);

    // Stall: slot full, no grants; then pop + accept together
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) cyc("stall", 1, 2'b00);
    bus.rsp_ready = 1'b1;
    cyc("pop_acc", 1, 2'b01);

    // Requester 1 lock sequence 1,1,0 against a busy requester 0
    bus.req_lock = 2'b10;
    cyc("lk1_a", 1, 2'b10);
    cyc("lk1_b", 1, 2'b10);
    bus.req_lock = 2'b00;
    cyc("lk1_c", 1, 2'b10);
    cyc("lk1_d", 1, 2'b01);

    // Requester 0 locks then idles; requester 1 waits out the timeout
    bus.req_valid = 2'b01;
    bus.req_lock  = 2'b01;
    cyc("lk0", 1, 2'b01);
    bus.req_valid = 2'b10;
    bus.req_lock  = 2'b00;
    for (int k = 0; k < 16; k++) cyc("tmo_wait", 1, 2'b00);
    cyc("tmo_rel", 1, 2'b10);

    // Illegal command, then an overflowing add
    auto_ops = 1'b0;
    bus.req_valid  = 2'b01;
    bus.req_cmd[0] = MIGU_ALU_NR_COMMANDS;
    bus.req_in1[0] = 64'h1234_5678_9abc_def0;
    bus.req_in2[0] = 64'h1;
    cyc("badcmd", 1, 2'b01);
    @(negedge clk);
    chk("err_rsp", {bus.rsp_err, bus.rsp_co, bus.rsp_out}, {1'b1, 1'b0, 64'h0});
    @(posedge clk); #1;
    bus.req_cmd[0] = ALU_ADD;
    bus.req_in1[0] = '1;
    bus.req_in2[0] = 64'h1;
    cyc("add_ovf", 1, 2'b01);
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("carry", {bus.rsp_err, bus.rsp_co, bus.rsp_out}, {1'b0, 1'b1, 64'h0});
    @(posedge clk); #1;
    auto_ops = 1'b1;
    rnd_op(0);

    // Random traffic, scoreboard only
    for (int k = 0; k < 300; k++) begin
      bus.req_valid = 2'($urandom);
      bus.req_lock  = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      cyc("", 0, 2'b00);
    end
    bus.req_valid = 2'b00;
    bus.req_lock  = 2'b00;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 20; k++) cyc("", 0, 2'b00);

    // Reset while locked with a pending response: lock released
    bus.req_valid = 2'b01;
    bus.req_lock  = 2'b01;
    cyc("rlk", 1, 2'b01);
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    cyc("rst_rdy2", 1, 2'b00);
    rst = 1'b0;
    chk("rst_drop", {bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_co, bus.rsp_out}, 0);
    bus.req_valid = 2'b10;
    bus.req_lock  = 2'b00;
    bus.rsp_ready = 1'b1;
    cyc("rst_idle", 1, 2'b10);

    // Reset restores prio=0 (it was 1 after the locked accept)
    bus.req_valid = 2'b01;
    bus.req_lock  = 2'b01;
    cyc("rlk2", 1, 2'b01);
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    cyc("rst_rdy3", 1, 2'b00);
    rst = 1'b0;
    chk("rst_drop2", {bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_co, bus.rsp_out}, 0);
    bus.req_valid = 2'b11;
    bus.req_lock  = 2'b00;
    bus.rsp_ready = 1'b1;
    cyc("rst_prio", 1, 2'b01);
    bus.req_valid = 2'b00;
    cyc("", 0, 2'b00);
    cyc("", 0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
